// File: rtl/nibble_serial_seq_pkg.sv
// Shared constants for the nibble-serial sequencer and its sumador datapath:
// nibble width, sequencer state encoding and ALUOp encodings.
package nibble_serial_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_AND = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

endpackage

// File: rtl/nibble_serial_seq.sv
// Feeds two wide operands through the 4-bit sumador one nibble per cycle, LSB first,
// chaining cout3 into the next Cin0; result valid with done, NIBBLES+1 cycles after accept.
module nibble_serial_seq
  import nibble_serial_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic [1:0]                  alu_op,
  input  logic                        l,
  input  logic                        cin,
  output logic [NIBBLE_W-1:0]         op1,
  output logic [NIBBLE_W-1:0]         op2,
  output logic [1:0]                  aluop_o,
  output logic                        l_o,
  output logic                        cin0_o,
  input  logic [NIBBLE_W-1:0]         r,
  input  logic                        cout3,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                        carry,
  output logic                        zero,
  output logic                        busy,
  output logic                        done
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     a_q, b_q;
  logic [W-1:0]     result_q, result_d;
  logic [1:0]       alu_op_q;
  logic             l_q, cin_q, chain_q, carry_q, zero_q;
  logic             in_run, last_nibble;

  assign in_run      = (state_q == RUN);
  assign last_nibble = in_run && (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result with the current nibble merged in, so the zero flag sees the final value.
  always_comb begin
    result_d = result_q;
    if (in_run) result_d[NIBBLE_W*int'(idx_q) +: NIBBLE_W] = r;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_op_q <= '0;
      l_q      <= 1'b0;
      cin_q    <= 1'b0;
      chain_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            alu_op_q <= alu_op;
            l_q      <= l;
            cin_q    <= cin;
            idx_q    <= '0;
          end
        end
        RUN: begin
          result_q <= result_d;
          chain_q  <= cout3;
          if (last_nibble) begin
            carry_q <= cout3;
            zero_q  <= (result_d == '0);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign op1     = in_run ? a_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W] : '0;
  assign op2     = in_run ? b_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W] : '0;
  assign cin0_o  = in_run ? ((idx_q == '0) ? cin_q : chain_q) : 1'b0;
  assign aluop_o = alu_op_q;
  assign l_o     = l_q;

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_nibble_serial_seq.sv
// Runs the sequencer against a behavioural 4-bit sumador and checks every operation
// against whole-word arithmetic (add: a+b+cin; logic ops: bitwise, no carry).
module tb_nibble_serial_seq;
  import nibble_serial_seq_pkg::*;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk, reset, start, l, cin;
  logic [W-1:0] a, b;
  logic [1:0]   alu_op;
  logic [3:0]   op1, op2, r;
  logic [1:0]   aluop_o;
  logic         l_o, cin0_o, cout3;
  logic [W-1:0] result;
  logic         carry, zero, busy, done;

  int checks   = 0;
  int failures = 0;

  nibble_serial_seq #(.NIBBLES(N)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .alu_op(alu_op),
    .l(l), .cin(cin), .op1(op1), .op2(op2), .aluop_o(aluop_o), .l_o(l_o),
    .cin0_o(cin0_o), .r(r), .cout3(cout3), .result(result), .carry(carry),
    .zero(zero), .busy(busy), .done(done)
  );

  // Behavioural sumador: add with carry, logic ops emit no carry.
  always_comb begin
    logic [4:0] s;
    s = {1'b0, op1} + {1'b0, op2} + {4'b0, cin0_o};
    case (aluop_o)
      ALU_ADD: {cout3, r} = s;
      ALU_AND: {cout3, r} = {1'b0, op1 & op2};
      ALU_OR:  {cout3, r} = {1'b0, op1 | op2};
      default: {cout3, r} = {1'b0, op1 ^ op2};
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one operation and checks busy/done timing, per-nibble drive and final flags.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [1:0] top,
                       input logic tl, input logic tcin, input bit glitch);
    logic [W-1:0] exp_res;
    logic         exp_carry;
    logic         exp_cin[N];
    longint       full;
    longint       mask;
    case (top)
      ALU_ADD: begin
        full      = longint'(ta) + longint'(tb_v) + longint'(tcin);
        exp_res   = full[W-1:0];
        exp_carry = full[W];
      end
      ALU_AND: begin exp_res = ta & tb_v; exp_carry = 1'b0; end
      ALU_OR:  begin exp_res = ta | tb_v; exp_carry = 1'b0; end
      default: begin exp_res = ta ^ tb_v; exp_carry = 1'b0; end
    endcase
    exp_cin[0] = tcin;
    for (int i = 1; i < N; i++) begin
      mask = (longint'(1) << (4 * i)) - 1;
      full = ((longint'(ta) & mask) + (longint'(tb_v) & mask) + longint'(tcin)) >> (4 * i);
      exp_cin[i] = (top == ALU_ADD) ? full[0] : 1'b0;
    end

    @(negedge clk);
    a = ta; b = tb_v; alu_op = top; l = tl; cin = tcin; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    for (int c = 1; c <= N; c++) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", c), {16'b0, busy}, 17'd1);
      chk($sformatf("done_c%0d", c), {16'b0, done}, 17'd0);
      chk($sformatf("cin0_c%0d", c), {16'b0, cin0_o}, {16'b0, exp_cin[c-1]});
      chk($sformatf("op1_c%0d", c), {13'b0, op1}, {13'b0, ta[4*(c-1) +: 4]});
      if (glitch && c == 2) begin start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; end
      if (glitch && c == 3) start = 1'b0;
    end
    @(negedge clk);
    chk("done_pulse", {16'b0, done}, 17'd1);
    chk("busy_in_done", {16'b0, busy}, 17'd0);
    chk("result", {1'b0, result}, {1'b0, exp_res});
    chk("carry", {16'b0, carry}, {16'b0, exp_carry});
    chk("zero", {16'b0, zero}, {16'b0, exp_res == '0});
    chk("aluop_hold", {15'b0, aluop_o}, {15'b0, top});
    chk("l_hold", {16'b0, l_o}, {16'b0, tl});
    chk("op1_idle", {13'b0, op1}, 17'd0);
    @(negedge clk);
    chk("done_drop", {16'b0, done}, 17'd0);
    chk("busy_idle", {16'b0, busy}, 17'd0);
    chk("result_stable", {1'b0, result}, {1'b0, exp_res});
  endtask

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; alu_op = '0; l = 1'b0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result", {1'b0, result}, 17'd0);
    chk("rst_flags", {14'b0, carry, zero, busy}, 17'd0);
    chk("rst_done", {16'b0, done}, 17'd0);
    chk("rst_ops", {9'b0, op1, op2}, 17'd0);
    chk("rst_ctl", {13'b0, aluop_o, l_o, cin0_o}, 17'd0);
    reset = 1'b0;

    do_op(16'h00FF, 16'h0001, ALU_ADD, 1'b0, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, ALU_ADD, 1'b0, 1'b0, 1'b0);
    do_op(16'h0000, 16'h0000, ALU_ADD, 1'b0, 1'b1, 1'b0);
    do_op(16'h1234, 16'h1111, ALU_ADD, 1'b1, 1'b0, 1'b1);

    // Reset in cycle 2 of RUN discards the partial result.
    @(negedge clk);
    a = 16'h8888; b = 16'h8888; alu_op = ALU_ADD; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", {16'b0, busy}, 17'd0);
    chk("midrst_done", {16'b0, done}, 17'd0);
    chk("midrst_result", {1'b0, result}, 17'd0);
    chk("midrst_carry", {16'b0, carry}, 17'd0);
    do_op(16'hABCD, 16'h1111, ALU_ADD, 1'b0, 1'b0, 1'b0);

    // Start held high for cycles 0..11: done exactly in cycles 5 and 11.
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; alu_op = ALU_ADD; cin = 1'b0; start = 1'b1;
    pulses = 0;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done) pulses++;
      chk($sformatf("held_done_c%0d", c), {16'b0, done}, {16'b0, (c == 5 || c == 11)});
      if (c == 11) start = 1'b0;
    end
    chk("held_pulses", 17'(pulses), 17'd2);
    chk("held_result", {1'b0, result}, 17'h01010);

    for (int i = 0; i < 20; i++)
      do_op(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
